// File: rtl/width_conv_512_64.sv
// AXI-Stream width down-converter: one wide beat in, RATIO narrow beats
// out, lane 0 first; define WIDTH_CONV_TKEEP_EN to add TKEEP lane trimming.
// Ports: aclk, areset (async, active-high), S_AXIS_* wide slave side,
// M_AXIS_* narrow master side, optional S_AXIS_TKEEP / M_AXIS_TKEEP.
module width_conv_512_64 #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 512,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
`ifdef WIDTH_CONV_TKEEP_EN
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
`endif
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int SW    = C_S00_AXIS_TDATA_WIDTH;
  localparam int MW    = C_M00_AXIS_TDATA_WIDTH;
  localparam int RATIO = SW / MW;
  localparam int CW    = $clog2(RATIO);
  localparam int KW    = MW / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RATIO-1:0][MW-1:0] lanes_q;
  logic                     last_q;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            fin_q;
  logic [CW-1:0]            fin_d;
  logic                     at_fin;
  logic                     s_hs;
  logic                     m_hs;

`ifdef WIDTH_CONV_TKEEP_EN
  logic [RATIO-1:0][KW-1:0] keep_q;
`endif

  assign at_fin = (cnt_q == fin_q);
  assign s_hs   = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_hs   = M_AXIS_TVALID & M_AXIS_TREADY;

  // Last lane to emit for an incoming beat: the top lane by default,
  // or the highest lane holding any kept byte (lane 0 if none).
  always_comb begin
    fin_d = '1;
`ifdef WIDTH_CONV_TKEEP_EN
    fin_d = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (|S_AXIS_TKEEP[k*KW +: KW]) fin_d = CW'(k);
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (s_hs) state_d = SEND;
      SEND: if (m_hs && at_fin && !s_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = (state_q == SEND);
    S_AXIS_TREADY = !areset &&
                    ((state_q == IDLE) ||
                     ((state_q == SEND) && M_AXIS_TREADY && at_fin));
    M_AXIS_TDATA  = '0;
    M_AXIS_TLAST  = 1'b0;
`ifdef WIDTH_CONV_TKEEP_EN
    M_AXIS_TKEEP  = '0;
`endif
    if (state_q == SEND) begin
      M_AXIS_TDATA = lanes_q[cnt_q];
      M_AXIS_TLAST = last_q & at_fin;
`ifdef WIDTH_CONV_TKEEP_EN
      M_AXIS_TKEEP = keep_q[cnt_q];
`endif
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lanes_q <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      fin_q   <= '0;
`ifdef WIDTH_CONV_TKEEP_EN
      keep_q  <= '0;
`endif
    end else if (s_hs) begin
      lanes_q <= S_AXIS_TDATA;
      last_q  <= S_AXIS_TLAST;
      cnt_q   <= '0;
      fin_q   <= fin_d;
`ifdef WIDTH_CONV_TKEEP_EN
      keep_q  <= S_AXIS_TKEEP;
`endif
    end else if (m_hs && !at_fin) begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule
